// File: rtl/gas_sim_pkg.sv
// Shared gas-simulation constants: piston geometry, level thresholds and gauge FSM encoding.
// The border counter and the piston gauge both derive their mappings from these values.
package gas_sim_pkg;

   localparam logic [15:0] PRESSURE_K = 16'd8000;
   localparam logic [7:0]  Q_MIN      = 8'd1;
   localparam logic [7:0]  Q_MAX      = 8'd200;

   // Border mapping: border = OFS - STEP*level; the thresholds below are its inverse
   localparam logic [7:0] BORDER_STEP     = 8'd40;
   localparam logic [7:0] TEMP_BORDER_OFS = 8'd161;
   localparam logic [7:0] MOLE_BORDER_OFS = 8'd201;

   localparam logic [7:0] TH_0 = 8'd1;
   localparam logic [7:0] TH_1 = 8'd41;
   localparam logic [7:0] TH_2 = 8'd81;
   localparam logic [7:0] TH_3 = 8'd121;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } gaugeState_t;

   function automatic logic [2:0] tempLevelOf(input logic [7:0] qc);
      if (qc <= TH_0)      return 3'd4;
      else if (qc <= TH_1) return 3'd3;
      else if (qc <= TH_2) return 3'd2;
      else if (qc <= TH_3) return 3'd1;
      else                 return 3'd0;
   endfunction

   function automatic logic [2:0] moleLevelOf(input logic [7:0] qc);
      if (qc <= TH_0)      return 3'd5;
      else if (qc <= TH_1) return 3'd4;
      else if (qc <= TH_2) return 3'd3;
      else if (qc <= TH_3) return 3'd2;
      else                 return 3'd1;
   endfunction

endpackage

// File: rtl/piston_gauge_if.sv
// Request/result bundle between the piston gauge and its consumer (display and mode logic).
interface piston_gauge_if;
   logic [7:0] Q;
   logic       sample;
   logic       busy;
   logic       valid;
   logic [7:0] pressure;
   logic [2:0] tempLevel;
   logic [2:0] moleLevel;

   modport master (output Q, sample, input busy, valid, pressure, tempLevel, moleLevel);
   modport slave  (input Q, sample, output busy, valid, pressure, tempLevel, moleLevel);
endinterface

// File: rtl/piston_gauge_seq_divider16.sv
// Iterative restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per cycle.
module seq_divider16 (
   input  logic        clk,
   input  logic        clearn,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic        done
);

   logic [15:0] quoReg;
   logic [7:0]  remReg;
   logic [7:0]  divReg;
   logic [3:0]  iterCnt;
   logic        running;
   logic [8:0]  shifted;
   logic [8:0]  trial;
   logic        fits;

   // Shift the next dividend bit into the partial remainder and try the subtraction
   assign shifted = {remReg, quoReg[15]};
   assign trial   = shifted - {1'b0, divReg};
   assign fits    = (shifted >= {1'b0, divReg});

   always_ff @(posedge clk) begin
      if (!clearn) begin
         running <= 1'b0;
         iterCnt <= 4'd0;
      end else if (start) begin
         running <= 1'b1;
         iterCnt <= 4'd0;
      end else if (running) begin
         iterCnt <= iterCnt + 4'd1;
         if (iterCnt == 4'd15) running <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         quoReg <= dividend;
         remReg <= 8'd0;
         divReg <= divisor;
      end else if (running) begin
         quoReg <= {quoReg[14:0], fits};
         remReg <= fits ? trial[7:0] : shifted[7:0];
      end
   end

   assign quotient = quoReg;
   assign done     = running && (iterCnt == 4'd15);

endmodule

// File: rtl/piston_gauge.sv
// Converts the piston position back into pressure, temperature level and mole level,
// using a shared sequential divider for P = K / V.
module piston_gauge #(
   parameter logic [15:0] PRESSURE_K = gas_sim_pkg::PRESSURE_K,
   parameter logic [7:0]  Q_MIN      = gas_sim_pkg::Q_MIN,
   parameter logic [7:0]  Q_MAX      = gas_sim_pkg::Q_MAX
) (
   input logic           clk,
   input logic           clearn,
   piston_gauge_if.slave bus
);

   import gas_sim_pkg::*;

   gaugeState_t state, stateNext;
   logic        divStart;
   logic        divDone;
   logic [15:0] quotient;
   logic [7:0]  qcIn;
   logic [7:0]  volIn;
   logic [2:0]  tempHold;
   logic [2:0]  moleHold;

   function automatic logic [7:0] clampPos(input logic [7:0] q);
      if (q < Q_MIN)      return Q_MIN;
      else if (q > Q_MAX) return Q_MAX;
      else                return q;
   endfunction

   function automatic logic [7:0] satPressure(input logic [15:0] quo);
      return (quo > 16'd255) ? 8'hFF : quo[7:0];
   endfunction

   // Clamp keeps V in 1..Q_MAX, so the divider never sees a zero divisor
   assign qcIn  = clampPos(bus.Q);
   assign volIn = Q_MAX + 8'd1 - qcIn;

   seq_divider16 uDiv (
      .clk      (clk),
      .clearn   (clearn),
      .start    (divStart),
      .dividend (PRESSURE_K),
      .divisor  (volIn),
      .quotient (quotient),
      .done     (divDone)
   );

   always_ff @(posedge clk) begin
      if (!clearn) state <= IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      divStart  = 1'b0;
      case (state)
         IDLE: if (bus.sample) begin
            divStart  = 1'b1;
            stateNext = DIV;
         end
         DIV:     if (divDone) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (divStart) begin
         tempHold <= tempLevelOf(qcIn);
         moleHold <= moleLevelOf(qcIn);
      end
   end

   // Result registers update only when leaving DONE and otherwise hold
   always_ff @(posedge clk) begin
      if (!clearn) begin
         bus.valid     <= 1'b0;
         bus.pressure  <= 8'd0;
         bus.tempLevel <= 3'd0;
         bus.moleLevel <= 3'd1;
      end else begin
         bus.valid <= (state == DONE);
         if (state == DONE) begin
            bus.pressure  <= satPressure(quotient);
            bus.tempLevel <= tempHold;
            bus.moleLevel <= moleHold;
         end
      end
   end

   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_piston_gauge.sv
// Directed bench for piston_gauge: conversions, clamping, ignored re-sample, abort and throughput.
module tb_piston_gauge;

   logic clk = 1'b0;
   logic clearn;
   int   checks = 0;
   int   errors = 0;

   piston_gauge_if bus ();

   piston_gauge dut (
      .clk    (clk),
      .clearn (clearn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutputs(input string tag, input logic [7:0] expP,
                               input logic [2:0] expT, input logic [2:0] expM);
      check({tag, "_pressure"}, 16'(bus.pressure), 16'(expP));
      check({tag, "_temp"},     16'(bus.tempLevel), 16'(expT));
      check({tag, "_mole"},     16'(bus.moleLevel), 16'(expM));
   endtask

   task automatic runConv(input string tag, input logic [7:0] q, input logic [7:0] expP,
                          input logic [2:0] expT, input logic [2:0] expM);
      int lat;
      @(negedge clk);
      bus.Q      = q;
      bus.sample = 1'b1;
      @(negedge clk);
      bus.sample = 1'b0;
      check({tag, "_busy"}, 16'(bus.busy), 16'd1);
      lat = 0;
      while (!bus.valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 16'(lat), 16'd17);
      checkOutputs(tag, expP, expT, expM);
      check({tag, "_busyAtValid"}, 16'(bus.busy), 16'd0);
      @(negedge clk);
      check({tag, "_validPulse"}, 16'(bus.valid), 16'd0);
      checkOutputs({tag, "_hold"}, expP, expT, expM);
   endtask

   initial begin
      int lat;
      int extraValid;
      int gap;

      clearn     = 1'b0;
      bus.Q      = 8'd0;
      bus.sample = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",  16'(bus.busy),  16'd0);
      check("rst_valid", 16'(bus.valid), 16'd0);
      checkOutputs("rst", 8'd0, 3'd0, 3'd1);
      clearn = 1'b1;

      runConv("q1",   8'd1,   8'd40,  3'd4, 3'd5);
      runConv("q121", 8'd121, 8'd100, 3'd1, 3'd2);
      runConv("q81",  8'd81,  8'd66,  3'd2, 3'd3);
      runConv("q200", 8'd200, 8'd255, 3'd0, 3'd1);
      runConv("q161", 8'd161, 8'd200, 3'd0, 3'd1);
      runConv("q0",   8'd0,   8'd40,  3'd4, 3'd5);
      runConv("q255", 8'd255, 8'd255, 3'd0, 3'd1);

      // Re-sample with a new position while the divider is busy: must be ignored
      @(negedge clk);
      bus.Q      = 8'd121;
      bus.sample = 1'b1;
      @(negedge clk);
      bus.sample = 1'b0;
      repeat (3) @(negedge clk);
      bus.Q      = 8'd1;
      bus.sample = 1'b1;
      @(negedge clk);
      bus.sample = 1'b0;
      check("ign_busy", 16'(bus.busy), 16'd1);
      lat = 4;
      while (!bus.valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("ign_latency", 16'(lat), 16'd17);
      checkOutputs("ign", 8'd100, 3'd1, 3'd2);
      extraValid = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.valid) extraValid++;
      end
      check("ign_extraValid", 16'(extraValid), 16'd0);
      check("ign_idle", 16'(bus.busy), 16'd0);

      // Reset in the middle of DIV discards the request
      @(negedge clk);
      bus.Q      = 8'd121;
      bus.sample = 1'b1;
      @(negedge clk);
      bus.sample = 1'b0;
      repeat (4) @(negedge clk);
      clearn = 1'b0;
      @(negedge clk);
      clearn = 1'b1;
      check("abort_busy",  16'(bus.busy),  16'd0);
      check("abort_valid", 16'(bus.valid), 16'd0);
      checkOutputs("abort", 8'd0, 3'd0, 3'd1);
      extraValid = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.valid) extraValid++;
      end
      check("abort_noValid", 16'(extraValid), 16'd0);
      runConv("q41", 8'd41, 8'd50, 3'd3, 3'd4);

      // Sample held high: one result every 18 cycles
      @(negedge clk);
      bus.Q      = 8'd81;
      bus.sample = 1'b1;
      lat = 0;
      while (!bus.valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_first", 16'(bus.valid), 16'd1);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!bus.valid && gap < 40);
      bus.sample = 1'b0;
      check("b2b_gap", 16'(gap), 16'd18);
      checkOutputs("b2b", 8'd66, 3'd2, 3'd3);
      repeat (25) @(negedge clk);
      check("b2b_idle", 16'(bus.busy), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
